// File: rtl/adder_64bit_serial.sv
// Multi-cycle 64-bit signed adder: A + B + Cin, one CHUNK_W-bit slice per clock, with the carry
// chained through a register. Operands and results move over valid/ready handshakes.
// Optional feature: define ADDER_SUB_MODE_EN to add a Sub input selecting A - B.
module adder_64bit_serial #(
  parameter int unsigned CHUNK_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] A,
  input  logic [63:0] B,
  input  logic        Cin,
`ifdef ADDER_SUB_MODE_EN
  input  logic        Sub,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] Result,
  output logic        Cout,
  output logic        Overflow
);

  localparam int unsigned NUM_CHUNKS = 64 / CHUNK_W;
  localparam int unsigned IdxW       = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  if ((CHUNK_W == 0) || (64 % CHUNK_W != 0)) begin : gen_bad_chunk
    $error("CHUNK_W must divide 64");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [63:0]       a_q, a_d;
  logic [63:0]       b_q, b_d;
  logic              carry_q, carry_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [63:0]       result_q, result_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;

  logic [CHUNK_W:0]  slice_sum;
  int unsigned       base;

  // State, operand, carry, index and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  // Next-state logic: accept in IDLE, one slice per RUN cycle, hold in DONE until drained.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    carry_d   = carry_q;
    idx_d     = idx_q;
    result_d  = result_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    base      = CHUNK_W * 32'(idx_q);
    slice_sum = {1'b0, a_q[base +: CHUNK_W]} + {1'b0, b_q[base +: CHUNK_W]}
              + {{CHUNK_W{1'b0}}, carry_q};

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = A;
          idx_d   = '0;
          state_d = StRun;
`ifdef ADDER_SUB_MODE_EN
          // Subtraction stored as A + ~B + 1 so RUN needs no mode knowledge.
          b_d     = Sub ? ~B : B;
          carry_d = Sub ? 1'b1 : Cin;
`else
          b_d     = B;
          carry_d = Cin;
`endif
        end
      end
      StRun: begin
        result_d[base +: CHUNK_W] = slice_sum[CHUNK_W-1:0];
        carry_d                   = slice_sum[CHUNK_W];
        idx_d                     = idx_q + IdxW'(1);
        if (idx_q == IdxW'(NUM_CHUNKS - 1)) begin
          cout_d  = slice_sum[CHUNK_W];
          // b_q already holds ~B when subtracting, so one rule covers both modes.
          ovf_d   = (a_q[63] == b_q[63]) && (result_d[63] != a_q[63]);
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign Result    = result_q;
  assign Cout      = cout_q;
  assign Overflow  = ovf_q;

endmodule

// File: tb/tb_adder_64bit_serial.sv
// Scoreboard bench for adder_64bit_serial: the driver pushes hand-computed expectations, a
// negedge monitor pops and compares on each output handshake and checks accept-to-valid latency.
module tb_adder_64bit_serial;

  localparam int unsigned CW = 16;
  localparam int unsigned NC = 64 / CW;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] A = '0;
  logic [63:0] B = '0;
  logic        Cin = 1'b0;
  logic        Sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] Result;
  logic        Cout;
  logic        Overflow;

  adder_64bit_serial #(.CHUNK_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
`ifdef ADDER_SUB_MODE_EN
    .Sub       (Sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Result    (Result),
    .Cout      (Cout),
    .Overflow  (Overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] res;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned acc_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;
  logic        ov_prev = 1'b0;
  exp_t        e;
  int unsigned acc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  // Monitor: latency on each out_valid rise, result/flags on each output handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && !ov_prev) begin
      if (acc_q.size() == 0) begin
        check("unexpected out_valid", 64'(out_valid), 64'd0);
      end else begin
        acc = acc_q.pop_front();
        check("latency", 64'(cyc - acc), 64'(NC));
      end
    end
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected result", 64'(out_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("result", Result, e.res);
        check("cout", 64'(Cout), 64'(e.cout));
        check("overflow", 64'(Overflow), 64'(e.ovf));
      end
    end
    ov_prev <= out_valid;
  end

  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic cin,
                      input logic sub, input logic [63:0] xres, input logic xcout,
                      input logic xovf, input bit push);
    int w;
    exp_t x;
    @(negedge clk);
    A = a; B = b; Cin = cin; Sub = sub; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      check("accept timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
    end else begin
      x.res = xres; x.cout = xcout; x.ovf = xovf;
      if (push) exp_q.push_back(x);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      if (push) acc_q.push_back(cyc);
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (exp_q.size() != 0) check("drain timeout", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout: got running, want finished");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    // Reset values, observed while reset is held.
    #12;
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset result", Result, 64'd0);
    check("reset cout", 64'(Cout), 64'd0);
    check("reset overflow", 64'(Overflow), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-reset in_ready", 64'(in_ready), 64'd1);

    send(64'd1, 64'd1, 1'b0, 1'b0, 64'd2, 1'b0, 1'b0, 1'b1);
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1);
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1);
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0,
         64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b1);
    send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'd0, 1'b1, 1'b1, 1'b1);
    send(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b1, 1'b0, 64'h0000_0001_0000_0001, 1'b0, 1'b0, 1'b1);
    drain();

    // Backpressure: hold the result in DONE for 5 cycles.
    out_ready = 1'b0;
    send(64'h1234, 64'h1, 1'b0, 1'b0, 64'h1235, 1'b0, 1'b0, 1'b1);
    w = 0;
    while (!out_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp out_valid", 64'(out_valid), 64'd1);
      check("bp result", Result, 64'h1235);
      check("bp in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("drain in_ready", 64'(in_ready), 64'd1);
    check("drain out_valid", 64'(out_valid), 64'd0);
    send(64'd10, 64'd20, 1'b0, 1'b0, 64'd30, 1'b0, 1'b0, 1'b1);
    drain();

    // Reset during the second RUN cycle: no result may appear.
    send(64'd5, 64'd6, 1'b0, 1'b0, 64'd11, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort out_valid", 64'(out_valid), 64'd0);
    check("abort result", Result, 64'd0);
    check("abort in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("abort idle out_valid", 64'(out_valid), 64'd0);

`ifdef ADDER_SUB_MODE_EN
    // Cin is ignored when subtracting.
    send(64'd5, 64'd7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b1);
    send(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b1);
    send(64'd3, 64'd4, 1'b1, 1'b0, 64'd8, 1'b0, 1'b0, 1'b1);
    drain();
`endif

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
